// File: rtl/cmd_pkt_pkg.sv
// cmd_pkt_pkg: shared types and constants for the command-packet receiver.
//   state_e  parser states
//   err_e    error code presented on pkt_err
//   CSUM_OK  value the modulo-256 sum of a whole packet must reach
package cmd_pkt_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_LEN,
        S_PAY,
        S_CSUM,
        S_HOLD
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CSUM = 2'd1,
        ERR_LEN  = 2'd2
    } err_e;

    localparam logic [7:0] CSUM_OK = 8'h00;

endpackage

// File: rtl/cmd_pkt_rx_if.sv
// cmd_pkt_rx_if: byte-stream input, packet output and payload read port of cmd_pkt_rx.
//   in_valid/in_data/in_ready     byte link (producer -> receiver)
//   pkt_valid/pkt_ready           parsed packet handshake (receiver -> consumer)
//   pkt_header/pkt_length/pkt_err packet fields
//   rd_idx/rd_data                payload read by index
// master = link producer / packet consumer side, slave = receiver.
interface cmd_pkt_rx_if #(
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             pkt_valid;
    logic             pkt_ready;
    logic [7:0]       pkt_header;
    logic [7:0]       pkt_length;
    logic [1:0]       pkt_err;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_data;

    modport master (
        output in_valid, in_data, pkt_ready, rd_idx,
        input  in_ready, pkt_valid, pkt_header, pkt_length, pkt_err, rd_data
    );

    modport slave (
        input  in_valid, in_data, pkt_ready, rd_idx,
        output in_ready, pkt_valid, pkt_header, pkt_length, pkt_err, rd_data
    );
endinterface

// File: rtl/cmd_pkt_csum_acc.sv
// cmd_pkt_csum_acc: 8-bit modulo-256 running sum.
//   clk, rst_n  clock, async active-low reset (sum resets to 0)
//   clr         restart the sum; with en the result is din, without en it is 0
//   en          add din into the sum
//   din         byte to add
//   sum         current registered sum
module cmd_pkt_csum_acc
    import cmd_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    logic [7:0] sum_q, sum_d;
    logic [7:0] base, addend;

    always_comb begin
        base   = clr ? 8'h00 : sum_q;
        addend = en  ? din   : 8'h00;
        // carry out of bit 7 is dropped: the sum is modulo 256 by construction
        sum_d  = base + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= 8'h00;
        else        sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/cmd_pkt_rx.sv
// cmd_pkt_rx: parses {header, length, payload[length], checksum} from a byte stream,
// buffers one packet and presents it on a valid/ready output.
//   clk, rst_n  clock, async active-low reset
//   bus         cmd_pkt_rx_if.slave: byte input, packet fields, payload read port
// Parameters: MAX_LEN payload bytes stored (1..255), IDX_W payload index width.
// Payload beyond MAX_LEN is consumed but not stored and flags ERR_LEN.
module cmd_pkt_rx
    import cmd_pkt_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    cmd_pkt_rx_if.slave  bus
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e                    state_q, state_d;
    logic [7:0]                hdr_q, hdr_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [1:0]                err_q, err_d;
    logic                      pkt_valid_q, pkt_valid_d;
    logic                      in_ready_q, in_ready_d;
    logic [MAX_LEN-1:0][7:0]   buf_q, buf_d;

    logic                      xfer;
    logic                      acc_clr, acc_en;
    logic [7:0]                acc_sum, csum_res, rd_lim;

    assign xfer = bus.in_valid && in_ready_q;

    cmd_pkt_csum_acc u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (bus.in_data),
        .sum   (acc_sum)
    );

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        pkt_valid_d = pkt_valid_q;
        in_ready_d  = in_ready_q;
        buf_d       = buf_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        // sum of the whole packet once the checksum byte is added
        csum_res    = acc_sum + bus.in_data;

        case (state_q)
            S_HDR: if (xfer) begin
                hdr_d   = bus.in_data;
                acc_clr = 1'b1;
                acc_en  = 1'b1;
                state_d = S_LEN;
            end
            S_LEN: if (xfer) begin
                len_d   = bus.in_data;
                acc_en  = 1'b1;
                cnt_d   = 8'd0;
                state_d = (bus.in_data == 8'd0) ? S_CSUM : S_PAY;
            end
            S_PAY: if (xfer) begin
                if (cnt_q < MAX_LEN_B) buf_d[cnt_q[IDX_W-1:0]] = bus.in_data;
                acc_en = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == len_q - 8'd1) state_d = S_CSUM;
            end
            S_CSUM: if (xfer) begin
                acc_en = 1'b1;
                // an overlength packet reports ERR_LEN whatever its checksum says
                if (len_q > MAX_LEN_B)         err_d = ERR_LEN;
                else if (csum_res != CSUM_OK)  err_d = ERR_CSUM;
                else                           err_d = ERR_NONE;
                pkt_valid_d = 1'b1;
                in_ready_d  = 1'b0;
                state_d     = S_HOLD;
            end
            S_HOLD: if (bus.pkt_ready) begin
                // in_ready is low here, so no header can slip in on the handoff cycle
                pkt_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR;
            hdr_q       <= 8'h00;
            len_q       <= 8'h00;
            cnt_q       <= 8'h00;
            err_q       <= 2'd0;
            pkt_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            pkt_valid_q <= pkt_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // payload storage is qualified by length on read, so it carries no reset
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.pkt_valid  = pkt_valid_q;
    assign bus.pkt_header = hdr_q;
    assign bus.pkt_length = len_q;
    assign bus.pkt_err    = err_q;

    always_comb begin
        rd_lim      = (len_q > MAX_LEN_B) ? MAX_LEN_B : len_q;
        bus.rd_data = 8'h00;
        if (8'(bus.rd_idx) < rd_lim) bus.rd_data = buf_q[bus.rd_idx];
    end

endmodule

// File: tb/tb_cmd_pkt_rx.sv
module tb_cmd_pkt_rx;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   gap_pct = 0;

    always #5 clk = ~clk;

    cmd_pkt_rx_if #(.IDX_W(4)) bus ();

    cmd_pkt_rx #(.MAX_LEN(16), .IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_bytes[$];
    logic       m_pending = 1'b0;
    logic [7:0] m_hdr = 8'h00, m_len = 8'h00;
    logic [1:0] m_err = 2'd0;
    logic [7:0] m_pay[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finalize();
        logic [7:0] s;
        int len;
        s = 8'h00;
        foreach (m_bytes[i]) s = s + m_bytes[i];
        len = int'(m_bytes[1]);
        m_hdr = m_bytes[0];
        m_len = m_bytes[1];
        m_err = (len > 16) ? 2'd2 : ((s != 8'h00) ? 2'd1 : 2'd0);
        for (int i = 0; i < 16; i++) m_pay[i] = (i < len) ? m_bytes[2+i] : 8'h00;
        m_pending = 1'b1;
        m_bytes.delete();
    endtask

    // Inputs change only at posedge+1, so the values seen here are the pre-edge ones.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_bytes.delete();
                m_pending = 1'b0;
            end else if (m_pending) begin
                if (bus.pkt_ready) m_pending = 1'b0;
            end else if (bus.in_valid) begin
                m_bytes.push_back(bus.in_data);
                if (m_bytes.size() >= 2 && m_bytes.size() == int'(m_bytes[1]) + 3) finalize();
            end
        end
    end

    // compare process
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cmp_in_ready", 32'(bus.in_ready), 32'(!m_pending));
                chk("cmp_pkt_valid", 32'(bus.pkt_valid), 32'(m_pending));
                if (m_pending) begin
                    chk("cmp_header", 32'(bus.pkt_header), 32'(m_hdr));
                    chk("cmp_length", 32'(bus.pkt_length), 32'(m_len));
                    chk("cmp_err", 32'(bus.pkt_err), 32'(m_err));
                    chk("cmp_rd_data", 32'(bus.rd_data), 32'(m_pay[bus.rd_idx]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.rd_idx = 4'($urandom_range(15));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  g;
        logic acc;
        if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        g = 0;
        do begin
            acc = bus.in_ready;
            tick();
            g++;
        end while (!acc && g < 40);
        if (!acc) chk("in_ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pkt(input bq_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic build(input logic [7:0] hdr, input int len, input bit ramp, input bit good,
                         output bq_t q);
        logic [7:0] s;
        q = {};
        q.push_back(hdr);
        q.push_back(8'(len));
        for (int i = 0; i < len; i++) q.push_back(ramp ? 8'(8'h40 + i) : 8'($urandom_range(255)));
        s = 8'h00;
        foreach (q[i]) s = s + q[i];
        q.push_back(good ? 8'(8'h00 - s) : 8'((8'h00 - s) ^ 8'(1 + $urandom_range(254))));
    endtask

    task automatic take_pkt(input int hold, input bit busy);
        int g = 0;
        while (!bus.pkt_valid && g < 40) begin tick(); g++; end
        if (!bus.pkt_valid) chk("pkt_valid_timeout", 32'd0, 32'd1);
        bus.pkt_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = busy;
            bus.in_data  = 8'($urandom_range(255));
            tick();
        end
        bus.pkt_ready = 1'b1;
        tick();
        bus.pkt_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("post_handoff_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_handoff_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] idx, input logic [7:0] exp);
        bus.rd_idx = idx;
        #1;
        chk(name, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic directed();
        bq_t q;
        // packet with two payload bytes
        q = {8'h2a, 8'h02, 8'h01, 8'h02, 8'hd1};
        send_pkt(q);
        chk("t1_latency_valid", 32'(bus.pkt_valid), 32'd1);
        chk("t1_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("t1_header", 32'(bus.pkt_header), 32'h2a);
        chk("t1_length", 32'(bus.pkt_length), 32'd2);
        chk("t1_err", 32'(bus.pkt_err), 32'd0);
        rd_chk("t1_rd0", 4'd0, 8'h01);
        rd_chk("t1_rd1", 4'd1, 8'h02);
        rd_chk("t1_rd2", 4'd2, 8'h00);
        take_pkt(0, 1'b0);
        // zero-length packet
        q = {8'h12, 8'h00, 8'hee};
        send_pkt(q);
        take_pkt_chk_empty();
        // bad checksum, then a good packet
        q = {8'h2a, 8'h02, 8'h01, 8'h02, 8'hd0};
        send_pkt(q);
        chk("t3_err", 32'(bus.pkt_err), 32'd1);
        take_pkt(1, 1'b0);
        q = {8'h12, 8'h00, 8'hee};
        send_pkt(q);
        chk("t3_next_err", 32'(bus.pkt_err), 32'd0);
        take_pkt(0, 1'b0);
        // overlength: 20 payload bytes, only 16 kept
        build(8'h55, 20, 1'b1, 1'b1, q);
        chk("t4_bytes", 32'(q.size()), 32'd23);
        send_pkt(q);
        chk("t4_valid", 32'(bus.pkt_valid), 32'd1);
        chk("t4_err", 32'(bus.pkt_err), 32'd2);
        chk("t4_length", 32'(bus.pkt_length), 32'd20);
        rd_chk("t4_rd15", 4'd15, 8'h4f);
        rd_chk("t4_rd0", 4'd0, 8'h40);
        take_pkt(0, 1'b0);
    endtask

    task automatic take_pkt_chk_empty();
        chk("t2_header", 32'(bus.pkt_header), 32'h12);
        chk("t2_length", 32'(bus.pkt_length), 32'd0);
        chk("t2_err", 32'(bus.pkt_err), 32'd0);
        for (int i = 0; i < 16; i++) rd_chk("t2_rd", 4'(i), 8'h00);
        take_pkt(0, 1'b0);
    endtask

    initial begin
        bq_t q;
        logic [7:0] h0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.pkt_ready = 1'b0;
        bus.rd_idx    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("rst_header", 32'(bus.pkt_header), 32'd0);
        chk("rst_length", 32'(bus.pkt_length), 32'd0);
        chk("rst_err", 32'(bus.pkt_err), 32'd0);
        rst_n = 1'b1;
        tick();

        gap_pct = 0;
        directed();
        gap_pct = 40;
        directed();
        gap_pct = 0;

        // consumer stalls while the link keeps offering bytes
        q = {8'h2a, 8'h02, 8'h01, 8'h02, 8'hd1};
        send_pkt(q);
        h0 = bus.pkt_header;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom_range(255));
            tick();
            chk("t5_in_ready_low", 32'(bus.in_ready), 32'd0);
            chk("t5_header_stable", 32'(bus.pkt_header), 32'(h0));
        end
        take_pkt(0, 1'b1);

        // reset mid-packet
        q = {8'h2a, 8'h02, 8'h01};
        send_pkt(q);
        rst_n = 1'b0;
        tick();
        tick();
        chk("t6_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        q = {8'h12, 8'h00, 8'hee};
        send_pkt(q);
        chk("t6_next_valid", 32'(bus.pkt_valid), 32'd1);
        take_pkt_chk_empty();

        // random packets against the model
        gap_pct = 30;
        for (int n = 0; n < 40; n++) begin
            build(8'($urandom_range(255)), int'($urandom_range(24)), 1'b0,
                  ($urandom_range(9) < 7), q);
            send_pkt(q);
            take_pkt(int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
